// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. It decodes and evaluates RV32I/RV64I base ALU ops in a
// single cycle. M-extension ops run on an iterative radix-2 multiply/divide
// engine that stalls the pipeline through in_ready while it is busy.
module alu_exec_unit #(
    parameter int unsigned XLEN   = 32,
    parameter bit          MDU_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide:   {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic                special_q, special_d;
    logic                valid_q, valid_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                ill_q, ill_d;

    logic                accept;
    logic [ShW-1:0]      shamt;
    logic [XLEN-1:0]     add_res, sub_res, sll_res, srl_res, sra_res, slt_res, sltu_res;
    logic [XLEN-1:0]     base_res;
    logic                dec_illegal, dec_md;

    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   div_step;

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, md_res;

    assign busy     = (state_q != StIdle);
    assign in_ready = !busy && !flush;
    assign accept   = in_valid && in_ready;

    // Base-op datapath: every candidate result computed in parallel.
    always_comb begin
        shamt    = op_b[ShW-1:0];
        add_res  = op_a + op_b;
        sub_res  = op_a - op_b;
        sll_res  = op_a << shamt;
        srl_res  = op_a >> shamt;
        sra_res  = $signed(op_a) >>> shamt;
        slt_res  = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        sltu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
    end

    // Decode alu_op/funct3/funct7 into a base result, an M-op request or illegal.
    always_comb begin
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        base_res    = '0;
        unique case (alu_op)
            2'b00: base_res = add_res;
            2'b01: base_res = sub_res;
            2'b10: begin
                if (funct7 == 7'b000_0000) begin
                    case (funct3)
                        3'b000: base_res = add_res;
                        3'b001: base_res = sll_res;
                        3'b010: base_res = slt_res;
                        3'b011: base_res = sltu_res;
                        3'b100: base_res = op_a ^ op_b;
                        3'b101: base_res = srl_res;
                        3'b110: base_res = op_a | op_b;
                        3'b111: base_res = op_a & op_b;
                    endcase
                end else if (funct7 == 7'b010_0000 && funct3 == 3'b000) begin
                    base_res = sub_res;
                end else if (funct7 == 7'b010_0000 && funct3 == 3'b101) begin
                    base_res = sra_res;
                end else if (funct7 == 7'b000_0001 && MDU_EN) begin
                    dec_md = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            2'b11: begin
                case (funct3)
                    3'b000: base_res = add_res;
                    3'b001: begin
                        if (funct7[5]) dec_illegal = 1'b1;
                        else           base_res    = sll_res;
                    end
                    3'b010: base_res = slt_res;
                    3'b011: base_res = sltu_res;
                    3'b100: base_res = op_a ^ op_b;
                    3'b101: base_res = funct7[5] ? sra_res : srl_res;
                    3'b110: base_res = op_a | op_b;
                    3'b111: base_res = op_a & op_b;
                endcase
            end
        endcase
    end

    // M-op operand setup: signedness per funct3, magnitudes and early-out detection.
    always_comb begin
        if (funct3[2]) begin
            a_signed = !funct3[0];
            b_signed = !funct3[0];
        end else begin
            // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
            a_signed = (funct3[1:0] != 2'b11);
            b_signed = !funct3[1];
        end
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == MinNeg) && (op_b == AllOnes);
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (!div_diff[XLEN]) begin
            div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and half/quotient/remainder selection for the DONE cycle.
    always_comb begin
        prod_fix = neg_q  ? -acc_q : acc_q;
        quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (f3_q[2]) begin
            md_res = f3_q[1] ? rem_fix : quo_fix;
        end else if (f3_q[1:0] == 2'b00) begin
            md_res = prod_fix[XLEN-1:0];
        end else begin
            md_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic for the FSM, the engine registers and the result registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        special_d = special_q;
        valid_d   = 1'b0;
        res_d     = res_q;
        ill_d     = ill_q;

        unique case (state_q)
            StIdle: begin
                if (accept && dec_md) begin
                    state_d   = funct3[2] ? StDiv : StMul;
                    cnt_d     = '0;
                    f3_d      = funct3;
                    ill_d     = 1'b0;
                    special_d = div_zero || div_ovf;
                    if (!funct3[2]) begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = 1'b0;
                    end else if (div_zero) begin
                        acc_d  = {op_a, AllOnes};
                        neg_d  = 1'b0;
                        rneg_d = 1'b0;
                    end else if (div_ovf) begin
                        acc_d  = {{XLEN{1'b0}}, MinNeg};
                        neg_d  = 1'b0;
                        rneg_d = 1'b0;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        mcand_d = b_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                    end
                end else if (accept) begin
                    valid_d = 1'b1;
                    ill_d   = dec_illegal;
                    res_d   = dec_illegal ? '0 : base_res;
                end
            end
            StMul: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) state_d = StDone;
            end
            StDiv: begin
                if (special_q) begin
                    state_d = StDone;
                end else begin
                    acc_d = div_step;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                res_d   = md_res;
            end
            default: state_d = StIdle;
        endcase

        // Flush drops whatever is in flight, including a result due this cycle.
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
            res_d   = res_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            special_q <= special_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
            ill_q     <= ill_d;
        end
    end

    // Outputs: base results come from res_q, M results are formed in DONE.
    always_comb begin
        out_valid  = (valid_q || (state_q == StDone)) && !flush;
        out_result = (state_q == StDone) ? md_res : res_q;
        out_zero   = (out_result == '0);
        illegal    = ill_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors plus random ops checked against
// a plain-arithmetic reference model.
module tb_alu_exec_unit;

    localparam logic [31:0] MinNeg = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;

    logic        in_ready, out_valid, out_zero, illegal, busy;
    logic [31:0] out_result;
    logic        nm_in_ready, nm_out_valid, nm_out_zero, nm_illegal, nm_busy;
    logic [31:0] nm_out_result;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.XLEN(32), .MDU_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .flush(flush), .out_valid(out_valid), .out_result(out_result),
        .out_zero(out_zero), .illegal(illegal), .busy(busy)
    );

    alu_exec_unit #(.XLEN(32), .MDU_EN(1'b0)) u_nomdu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nm_in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .flush(flush), .out_valid(nm_out_valid), .out_result(nm_out_result),
        .out_zero(nm_out_zero), .illegal(nm_illegal), .busy(nm_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_base(input logic [2:0] f3, input logic alt,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return sa >>> b[4:0];
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == MinNeg) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return MinNeg;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic void ref_model(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic ill, output logic md, output int lat);
        res = '0; ill = 1'b0; md = 1'b0; lat = 1;
        case (op)
            2'b00: res = a + b;
            2'b01: res = a - b;
            2'b10: begin
                if (f7 == 7'h00) res = ref_base(f3, 1'b0, a, b);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) res = ref_base(f3, 1'b1, a, b);
                else if (f7 == 7'h01) begin
                    md  = 1'b1;
                    res = ref_md(f3, a, b);
                    lat = 33;
                    if (f3[2] && (b == 0 || (!f3[0] && a == MinNeg && b == 32'hFFFF_FFFF)))
                        lat = 2;
                end else ill = 1'b1;
            end
            default: begin
                if (f3 == 3'd1 && f7[5]) ill = 1'b1;
                else if (f3 == 3'd5) res = ref_base(f3, f7[5], a, b);
                else res = ref_base(f3, 1'b0, a, b);
            end
        endcase
        if (ill) res = '0;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MinNeg;
            3: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_base(output logic [1:0] op, output logic [2:0] f3, output logic [6:0] f7);
        op = 2'($urandom_range(0, 3));
        f3 = 3'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h00;
            default: f7 = 7'($urandom);
        endcase
        if (op == 2'b10 && f7 == 7'h01) f7 = 7'h00;
    endtask

    // Issue one op, then wait (bounded) for out_valid and capture what was seen.
    task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic acc_ok, output int lat, output logic [31:0] res,
                            output logic zero, output logic ill, output logic stall_ok,
                            output logic rdy_v);
        @(negedge clk);
        acc_ok   = in_ready;
        in_valid = 1'b1; alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; stall_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = out_result; zero = out_zero; ill = illegal; rdy_v = in_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_result, out_zero, illegal, busy, in_ready} !== {1'b0, 32'd0, 4'b1001})
            $display("FAIL reset_state: got v=%b r=%h z=%b ill=%b busy=%b rdy=%b want 0/0/1/0/0/1",
                     out_valid, out_result, out_zero, illegal, busy, in_ready);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001)
            $display("FAIL idle_after_reset: got v=%b busy=%b rdy=%b", out_valid, busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_base_ops();
        logic [1:0]  ops  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        logic [2:0]  f3s  [4] = '{3'd0, 3'd0, 3'd5, 3'd3};
        logic [6:0]  f7s  [4] = '{7'h00, 7'h00, 7'h20, 7'h00};
        logic [31:0] as   [4] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd1};
        logic [31:0] bs   [4] = '{32'd1, 32'd5, 32'd4, 32'hFFFF_FFFF};
        logic [31:0] exps [4] = '{32'h8000_0000, 32'd0, 32'hF800_0000, 32'd1};
        logic acc_ok, zero, ill, stall_ok, rdy_v, e_ill, e_md;
        logic [31:0] res, e_res;
        int lat, e_lat;
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], f3s[i], f7s[i], as[i], bs[i], acc_ok, lat, res, zero, ill,
                     stall_ok, rdy_v);
            n_checks++;
            if (res !== exps[i] || zero !== (exps[i] == 0))
                $display("FAIL base_directed_%0d: got %h z=%b want %h", i, res, zero, exps[i]);
            else n_pass++;
            n_checks++;
            if (lat !== 1 || acc_ok !== 1'b1 || rdy_v !== 1'b1)
                $display("FAIL base_latency_%0d: got lat=%0d acc=%b want 1/1", i, lat, acc_ok);
            else n_pass++;
        end
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op; logic [2:0] f3; logic [6:0] f7; logic [31:0] a, b;
            rand_base(op, f3, f7);
            a = rand_word(); b = rand_word();
            ref_model(op, f3, f7, a, b, e_res, e_ill, e_md, e_lat);
            drive_op(op, f3, f7, a, b, acc_ok, lat, res, zero, ill, stall_ok, rdy_v);
            n_checks++;
            if (res !== e_res || ill !== e_ill || zero !== (e_res == 0) || lat !== 1)
                $display("FAIL base_random op=%b f3=%0d f7=%h a=%h b=%h: got %h ill=%b lat=%0d want %h ill=%b",
                         op, f3, f7, a, b, res, ill, lat, e_res, e_ill);
            else n_pass++;
        end
    endtask

    // Shared body for M-op tables: fixed or random operands against the model.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int want_lat, input string tag);
        logic acc_ok, zero, ill, stall_ok, rdy_v;
        logic [31:0] res;
        int lat;
        drive_op(2'b10, f3, 7'h01, a, b, acc_ok, lat, res, zero, ill, stall_ok, rdy_v);
        n_checks++;
        if (res !== want || zero !== (want == 0) || ill !== 1'b0)
            $display("FAIL %s_result f3=%0d a=%h b=%h: got %h z=%b ill=%b want %h",
                     tag, f3, a, b, res, zero, ill, want);
        else n_pass++;
        n_checks++;
        if (lat !== want_lat)
            $display("FAIL %s_latency f3=%0d a=%h b=%h: got %0d want %0d", tag, f3, a, b, lat, want_lat);
        else n_pass++;
        n_checks++;
        if (acc_ok !== 1'b1 || stall_ok !== 1'b1 || rdy_v !== 1'b0)
            $display("FAIL %s_stall: got acc=%b stall=%b rdy_at_valid=%b want 1/1/0",
                     tag, acc_ok, stall_ok, rdy_v);
        else n_pass++;
    endtask

    task automatic test_mul();
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33, "mulh");
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] f3; logic [31:0] a, b, e_res; logic e_ill, e_md; int e_lat;
            f3 = 3'($urandom_range(0, 3));
            a = rand_word(); b = rand_word();
            ref_model(2'b10, f3, 7'h01, a, b, e_res, e_ill, e_md, e_lat);
            run_md(f3, a, b, e_res, e_lat, "mul_rand");
        end
    endtask

    task automatic test_div();
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run_md(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
        run_md(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
        for (int i = 0; i < 10; i++) begin
            logic [2:0] f3; logic [31:0] a, b, e_res; logic e_ill, e_md; int e_lat;
            f3 = 3'($urandom_range(4, 7));
            a = rand_word(); b = rand_word();
            ref_model(2'b10, f3, 7'h01, a, b, e_res, e_ill, e_md, e_lat);
            run_md(f3, a, b, e_res, e_lat, "div_rand");
        end
    endtask

    task automatic test_div_corner();
        run_md(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_by_zero");
        run_md(3'd6, 32'd5, 32'd0, 32'd5, 2, "rem_by_zero");
        run_md(3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, "divu_by_zero");
        run_md(3'd4, MinNeg, 32'hFFFF_FFFF, MinNeg, 2, "div_ovf");
        run_md(3'd6, MinNeg, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");
    endtask

    task automatic test_illegal();
        logic acc_ok, zero, ill, stall_ok, rdy_v;
        logic [31:0] res;
        int lat;
        drive_op(2'b10, 3'd7, 7'h20, 32'hDEAD_BEEF, 32'h1, acc_ok, lat, res, zero, ill,
                 stall_ok, rdy_v);
        n_checks++;
        if (ill !== 1'b1 || res !== 32'd0 || lat !== 1)
            $display("FAIL illegal_rtype: got ill=%b res=%h lat=%0d want 1/0/1", ill, res, lat);
        else n_pass++;
        drive_op(2'b11, 3'd1, 7'h20, 32'h5, 32'h1, acc_ok, lat, res, zero, ill, stall_ok, rdy_v);
        n_checks++;
        if (ill !== 1'b1 || res !== 32'd0)
            $display("FAIL illegal_slli: got ill=%b res=%h want 1/0", ill, res);
        else n_pass++;
        // MUL on the MDU_EN=0 instance decodes as illegal; main instance multiplies.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd0; funct7 = 7'h01; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({nm_out_valid, nm_illegal, nm_busy} !== 3'b110 || nm_out_result !== 32'd0)
            $display("FAIL nomdu_mul: got v=%b ill=%b busy=%b res=%h want 1/1/0/0",
                     nm_out_valid, nm_illegal, nm_busy, nm_out_result);
        else n_pass++;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (out_result !== 32'd15 || lat !== 33)
            $display("FAIL mdu_mul_alongside: got %h lat=%0d want 0000000f lat=33", out_result, lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_res [10];
        logic        e_ill [10];
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({out_valid, illegal, out_result} !== {1'b1, e_ill[i-1], e_res[i-1]})
                    $display("FAIL back_to_back_%0d: got v=%b ill=%b res=%h want 1/%b/%h", i - 1,
                             out_valid, illegal, out_result, e_ill[i-1], e_res[i-1]);
                else n_pass++;
            end
            if (i < 10) begin
                logic [1:0] op; logic [2:0] f3; logic [6:0] f7; logic [31:0] a, b;
                logic md; int lat;
                rand_base(op, f3, f7);
                a = rand_word(); b = rand_word();
                ref_model(op, f3, f7, a, b, e_res[i], e_ill[i], md, lat);
                n_checks++;
                if (in_ready !== 1'b1)
                    $display("FAIL back_to_back_ready_%0d: got %b want 1", i, in_ready);
                else n_pass++;
                in_valid = 1'b1; alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_flush();
        logic seen;
        // Flush during a DIVU: no result, ready again two cycles later.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd5; funct7 = 7'h01;
        op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_cycle: got rdy=%b v=%b want 0/0", in_ready, out_valid);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL flush_idle: got busy=%b want 0", busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL flush_ready_n12: got %b want 1", in_ready);
        else n_pass++;
        repeat (30) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL flush_no_valid: got out_valid pulse=%b want 0", seen);
        else n_pass++;
        // Flush in the cycle a base result is due suppresses its pulse.
        in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_base_valid: got %b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic acc_ok, zero, ill, stall_ok, rdy_v, seen;
        logic [31:0] res;
        int lat;
        drive_op(2'b00, 3'd0, 7'h00, 32'd3, 32'd4, acc_ok, lat, res, zero, ill, stall_ok, rdy_v);
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd0; funct7 = 7'h01;
        op_a = 32'd123; op_b = 32'd456;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_result, out_zero, illegal, busy, in_ready} !== {1'b0, 32'd0, 4'b1001})
            $display("FAIL reset_mid_mul: got v=%b r=%h z=%b ill=%b busy=%b rdy=%b want 0/0/1/0/0/1",
                     out_valid, out_result, out_zero, illegal, busy, in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL reset_mid_no_valid: got pulse=%b want 0", seen);
        else n_pass++;
        drive_op(2'b01, 3'd0, 7'h00, 32'd10, 32'd4, acc_ok, lat, res, zero, ill, stall_ok, rdy_v);
        n_checks++;
        if (res !== 32'd6 || lat !== 1 || acc_ok !== 1'b1)
            $display("FAIL reset_mid_recover: got %h lat=%0d acc=%b want 6/1/1", res, lat, acc_ok);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_base_ops();
        test_mul();
        test_div();
        test_div_corner();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
